// File: rtl/vga_line_pingpong.sv
// vga_line_pingpong: two-bank ping-pong line buffer between the frame fetch engine and the VGA timing controller.
// Optional colour-bar generator on the drain side, enabled by defining VGA_LINE_PINGPONG_TESTPAT_EN.
module vga_line_pingpong #(
  parameter int                DATA_W        = 12,
  parameter int                DEPTH         = 640,
  parameter int                AW            = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] UNDERFLOW_PIX = 12'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              fill_req_o,
  input  logic              data_req_i,
  output logic [DATA_W-1:0] data_o,
  output logic              underflow_o,
  output logic [1:0]        bank_full_o
`ifdef VGA_LINE_PINGPONG_TESTPAT_EN
  ,
  input  logic              testpat_i
`endif
);

  logic [DATA_W-1:0] mem0_r [DEPTH];
  logic [DATA_W-1:0] mem1_r [DEPTH];

  logic              wsel_r;
  logic              rsel_r;
  logic [AW-1:0]     wr_addr_r;
  logic [AW-1:0]     rd_addr_r;
  logic [1:0]        bank_full_r;
  logic [DATA_W-1:0] data_r;
  logic              underflow_r;
  logic              fill_req_r;

  logic              wr_ready_s;
  logic              wr_en_s;
  logic              wr_last_s;
  logic              rd_hit_s;
  logic              rd_last_s;
  logic [1:0]        bank_full_nxt_s;
  logic [DATA_W-1:0] rd_word_s;
  logic              pat_s;
  logic [DATA_W-1:0] pat_pix_s;

  assign wr_ready_s = ~bank_full_r[wsel_r];
  assign wr_en_s    = wr_valid_i & wr_ready_s & ~flush_i;
  assign wr_last_s  = wr_en_s & (wr_addr_r == AW'(DEPTH - 1));
  assign rd_hit_s   = data_req_i & bank_full_r[rsel_r] & ~pat_s & ~flush_i;
  assign rd_last_s  = rd_hit_s & (rd_addr_r == AW'(DEPTH - 1));
  assign rd_word_s  = rsel_r ? mem1_r[rd_addr_r] : mem0_r[rd_addr_r];

  // Fill and drain completions always hit opposite banks, so each flag has one writer per cycle.
  assign bank_full_nxt_s[0] = (wr_last_s && !wsel_r) ? 1'b1 :
                              (rd_last_s && !rsel_r) ? 1'b0 : bank_full_r[0];
  assign bank_full_nxt_s[1] = (wr_last_s &&  wsel_r) ? 1'b1 :
                              (rd_last_s &&  rsel_r) ? 1'b0 : bank_full_r[1];

`ifdef VGA_LINE_PINGPONG_TESTPAT_EN
  localparam int BAR_LEN = (DEPTH / 8 > 0) ? DEPTH / 8 : 1;

  logic [AW-1:0] rd_col_r;
  logic [2:0]    bar_idx_s;

  assign pat_s     = testpat_i & data_req_i & ~flush_i;
  assign bar_idx_s = 3'(rd_col_r / AW'(BAR_LEN));
  assign pat_pix_s = DATA_W'({{4{bar_idx_s[2]}}, {4{bar_idx_s[1]}}, {4{bar_idx_s[0]}}});

  // Column counter for the colour bars: one step per request, wrapping at the line length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_col_r <= {AW{1'b0}};
    end else if (flush_i) begin
      rd_col_r <= {AW{1'b0}};
    end else if (data_req_i) begin
      rd_col_r <= (rd_col_r == AW'(DEPTH - 1)) ? {AW{1'b0}} : rd_col_r + AW'(1);
    end else begin
      rd_col_r <= rd_col_r;
    end
  end
`else
  assign pat_s     = 1'b0;
  assign pat_pix_s = {DATA_W{1'b0}};
`endif

  // Line storage: write port only, no reset so both banks map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      if (wsel_r) begin
        mem1_r[wr_addr_r] <= wr_data_i;
      end else begin
        mem0_r[wr_addr_r] <= wr_data_i;
      end
    end
  end

  // Bank pointers, full flags and the registered drain-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wsel_r      <= 1'b0;
      rsel_r      <= 1'b0;
      wr_addr_r   <= {AW{1'b0}};
      rd_addr_r   <= {AW{1'b0}};
      bank_full_r <= 2'b00;
      data_r      <= {DATA_W{1'b0}};
      underflow_r <= 1'b0;
      fill_req_r  <= 1'b0;
    end else if (flush_i) begin
      wsel_r      <= 1'b0;
      rsel_r      <= 1'b0;
      wr_addr_r   <= {AW{1'b0}};
      rd_addr_r   <= {AW{1'b0}};
      bank_full_r <= 2'b00;
      data_r      <= {DATA_W{1'b0}};
      underflow_r <= 1'b0;
      fill_req_r  <= 1'b1;
    end else begin
      bank_full_r <= bank_full_nxt_s;
      fill_req_r  <= rd_last_s;

      if (wr_last_s) begin
        wr_addr_r <= {AW{1'b0}};
        wsel_r    <= ~wsel_r;
      end else if (wr_en_s) begin
        wr_addr_r <= wr_addr_r + AW'(1);
      end else begin
        wr_addr_r <= wr_addr_r;
      end

      // The pattern overrides the buffer and never flags underflow.
      if (pat_s) begin
        data_r <= pat_pix_s;
      end else if (rd_last_s) begin
        data_r    <= rd_word_s;
        rd_addr_r <= {AW{1'b0}};
        rsel_r    <= ~rsel_r;
      end else if (rd_hit_s) begin
        data_r    <= rd_word_s;
        rd_addr_r <= rd_addr_r + AW'(1);
      end else if (data_req_i) begin
        data_r      <= UNDERFLOW_PIX;
        underflow_r <= 1'b1;
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign wr_ready_o  = wr_ready_s;
  assign fill_req_o  = fill_req_r;
  assign data_o      = data_r;
  assign underflow_o = underflow_r;
  assign bank_full_o = bank_full_r;

endmodule

// File: doc/vga_line_pingpong.md
Name: vga_line_pingpong

Overview:
- Two-bank ping-pong line buffer sitting directly upstream of the VGA timing controller.
- Fill side: accepts pixel words from the frame fetch/DMA engine through a valid/ready handshake.
- Drain side: returns one registered pixel per cycle to the timing controller whenever its data request is high.
- Raises a refill request each time a bank drains, so the fetch engine can stay one line ahead of the scan.

Parameters:
- DATA_W, 12, pixel width; bits [3:0] red, [7:4] green, [11:8] blue.
- DEPTH, 640, pixels per bank (one visible line); must be ≥ 2.
- AW, $clog2(DEPTH), bank address width.
- UNDERFLOW_PIX, 12'h000, value driven on data_o when a request finds no full bank.

Ports:
- clk, input, 1, pixel clock; the single clock of the block.
- rst, input, 1, asynchronous active-high reset.
- flush_i, input, 1, synchronous clear of both banks and all pointers (pulsed at frame start).
- wr_valid_i, input, 1, fill-side data valid.
- wr_ready_o, output, 1, fill-side ready.
- wr_data_i, input, DATA_W, fill-side pixel.
- fill_req_o, output, 1, one-cycle pulse: a bank became empty; the fetch engine supplies DEPTH pixels.
- data_req_i, input, 1, pixel request from the timing controller.
- data_o, output, DATA_W, registered pixel.
- underflow_o, output, 1, sticky: a request found no full read bank.
- bank_full_o, output, 2, per-bank full flags (debug/status).

Behaviour:
- Reset, asynchronous on rst high:
  - data_o = 0, underflow_o = 0, fill_req_o = 0, bank_full_o = 2'b00.
  - wsel = 0, rsel = 0, wr_addr = 0, rd_addr = 0.
- Storage: two DEPTH×DATA_W arrays, read synchronously (inferable as RAM).
- Bank state: each bank is EMPTY or FULL (a bank being written is EMPTY with wr_addr > 0).
- Fill side:
  - wr_ready_o = ~bank_full[wsel]; combinational from registered state only.
  - A write is accepted when wr_valid_i & wr_ready_o: writes mem[wsel][wr_addr], then wr_addr += 1.
  - On the accept at wr_addr == DEPTH-1: wr_addr ← 0, bank_full[wsel] ← 1, wsel toggles.
- Drain side:
  - On data_req_i with bank_full[rsel] = 1: data_o ← mem[rsel][rd_addr] on the next clock edge (latency 1, aligned with the controller's registered blank), then rd_addr += 1.
  - On the read at rd_addr == DEPTH-1: rd_addr ← 0, bank_full[rsel] ← 0, rsel toggles, fill_req_o pulses high for exactly the following cycle.
  - On data_req_i with bank_full[rsel] = 0: data_o ← UNDERFLOW_PIX, underflow_o ← 1 (sticky), rd_addr does not advance.
  - With data_req_i low, data_o holds its last value.
- Simultaneous events:
  - Fill completion and drain completion in the same cycle act on opposite banks; both take effect.
  - A write and a read never target the same bank (a full bank is never written; an empty bank is never read).
- flush_i (synchronous, highest priority):
  - Clears bank_full, wsel, rsel, wr_addr, rd_addr and underflow_o.
  - Forces fill_req_o high for one cycle so the fetch engine restarts.
  - A write or read in the same cycle is ignored; data_o ← 0.
- Reset or flush mid-line discards all partial data; no pixel from before the clear is ever returned.
- Steady state: after two lines are filled, bank_full_o = 2'b11 and wr_ready_o = 0 until the first read bank drains.

Optional Feature:
- Macro: VGA_LINE_PINGPONG_TESTPAT_EN.
- With the macro defined:
  - An extra input testpat_i (1 bit) is present.
  - When testpat_i = 1, each data_req_i cycle returns a colour-bar pattern instead of buffer contents: 8 bars, bar index = rd_col[AW-1:0] / (DEPTH/8).
  - Bar colour: red = {4{idx[0]}}, green = {4{idx[1]}}, blue = {4{idx[2]}}.
  - rd_col counts requests within the line and wraps at DEPTH.
  - The fill side is unaffected.
  - underflow_o does not set while the pattern is active.
- Without the macro: no testpat_i port and no pattern logic.

Test Plan:
1. Reset and idle: hold rst 3 cycles, then release → data_o = 0, wr_ready_o = 1, bank_full_o = 00, underflow_o = 0.
2. Single line: write DEPTH pixels 0..DEPTH-1 with wr_valid_i held high → bank_full_o = 01; then assert data_req_i for DEPTH cycles → data_o = 0,1,…,DEPTH-1, each one cycle after its request; fill_req_o pulses once after the last read; bank_full_o = 00.
3. Back-pressure: write 2·DEPTH+5 pixels with no reads → exactly 2·DEPTH accepted, wr_ready_o = 0, bank_full_o = 11; after one full drain, wr_ready_o = 1 and the remaining 5 pixels land in bank 0.
4. Underflow: data_req_i with empty banks → data_o = 12'h000, underflow_o = 1 and stays set; flush_i → underflow_o = 0, fill_req_o pulses.
5. Concurrent: bank 1 filling while bank 0 drains, with both last transfers on the same cycle → both flags update; the next line reads bank 1 correctly with no lost or duplicated pixel.
6. Async reset mid-line: assert rst between clock edges after 100 reads → outputs clear immediately; after release, reads return only newly written data.
